// File: rtl/link_rx_deframer.sv
// link_rx_deframer: oversampling start/data/stop serial receiver with ready/valid byte output.
// Define LINK_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module link_rx_deframer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  frame_err,
  output logic                  overrun,
`ifdef LINK_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  rx_busy
);
  localparam int IW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] HALF = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state;
  logic [1:0]            sync;
  logic [1:0]            vld;
  logic                  hi;
  logic                  rx_s;
  logic                  good;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shreg;
`ifdef LINK_RX_PARITY_EN
  logic                  perr;
  assign good = rx_s && !perr;
`else
  assign good = rx_s;
`endif
  assign rx_s = sync[1];
  // vld marks when rx_s reflects the real line, so a line low at reset release never starts a frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync       <= 2'b11;
      vld        <= 2'b00;
      hi         <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      rx_busy    <= 1'b0;
`ifdef LINK_RX_PARITY_EN
      perr       <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync      <= {sync[0], rx};
      vld       <= {vld[0], 1'b1};
      hi        <= vld[1] & rx_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef LINK_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (dout_valid && dout_ready) dout_valid <= 1'b0;
      case (state)
        IDLE: if (hi && !rx_s) begin
          state   <= START;
          cnt     <= HALF;
          rx_busy <= 1'b1;
        end
        START: if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else begin
            state <= DATA;
            cnt   <= FULL;
            idx   <= '0;
          end
        DATA: if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
            cnt   <= FULL;
            idx   <= idx + 1'b1;
`ifdef LINK_RX_PARITY_EN
            if (idx == LAST) state <= PARITY;
`else
            if (idx == LAST) state <= STOP;
`endif
          end
`ifdef LINK_RX_PARITY_EN
        PARITY: if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            perr  <= rx_s ^ (^shreg);
            cnt   <= FULL;
            state <= STOP;
          end
`endif
        STOP: if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            state     <= IDLE;
            rx_busy   <= 1'b0;
            frame_err <= !rx_s;
`ifdef LINK_RX_PARITY_EN
            parity_err <= perr;
`endif
            if (good && (!dout_valid || dout_ready)) begin
              dout       <= shreg;
              dout_valid <= 1'b1;
            end else if (good) overrun <= 1'b1;
          end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_link_rx_deframer.sv
// tb_link_rx_deframer: directed scenario tasks for link_rx_deframer at default parameters.
`timescale 1ns/1ps
module tb_link_rx_deframer;
  localparam int N = 16;
`ifdef LINK_RX_PARITY_EN
  localparam int PB = 1;
  logic parity_err;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = 155 + N * PB;
  logic clk = 0, rst = 1, rx = 1, dout_ready = 1;
  logic [7:0] dout;
  logic dout_valid, frame_err, overrun, rx_busy;
  int checks = 0, errors = 0;
  int cyc = 0, vcnt, fe_cnt, ov_cnt, pe_cnt, busy_cnt, rise_cyc, fe_cyc;
  logic pv = 0;
  logic [7:0] got[$];

  link_rx_deframer dut (
    .clk(clk), .rst(rst), .rx(rx), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .frame_err(frame_err), .overrun(overrun),
`ifdef LINK_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .rx_busy(rx_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dout_valid && dout_ready) got.push_back(dout);
    if (dout_valid) begin
      vcnt++;
      if (!pv) rise_cyc = cyc;
    end
    pv = dout_valid;
    if (frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (overrun) ov_cnt++;
    if (rx_busy) busy_cnt++;
`ifdef LINK_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic clear();
    got.delete();
    vcnt = 0; fe_cnt = 0; ov_cnt = 0; pe_cnt = 0; busy_cnt = 0;
    rise_cyc = -1; fe_cyc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bitp(input logic v);
    rx = v;
    idle(N);
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input logic pflip = 1'b0);
    bitp(1'b0);
    for (int i = 0; i < 8; i++) bitp(b[i]);
`ifdef LINK_RX_PARITY_EN
    bitp(^b ^ pflip);
`endif
    bitp(stop);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1; rx = 0;
    idle(3);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", frame_err, overrun); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", rx_busy); end
    clear();
    rst = 0;
    idle(40);
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL low_at_release busy_cycles got %0d exp 0", busy_cnt); end
    rx = 1;
    idle(20);
  endtask

  task automatic test_clean();
    int c0;
    clear();
    c0 = cyc;
    send(8'hA5, 1'b1);
    idle(40);
    checks++; if (got.size() != 1 || got[0] !== 8'hA5) begin errors++; $display("FAIL clean_byte got n=%0d %h exp 1 a5", got.size(), got.size() ? got[0] : 8'hxx); end
    checks++; if (rise_cyc != c0 + LAT) begin errors++; $display("FAIL clean_latency got %0d exp %0d", rise_cyc - c0, LAT); end
    checks++; if (vcnt != 1) begin errors++; $display("FAIL clean_valid_width got %0d exp 1", vcnt); end
    checks++; if (fe_cnt != 0 || ov_cnt != 0) begin errors++; $display("FAIL clean_flags got fe=%0d ov=%0d exp 0 0", fe_cnt, ov_cnt); end
  endtask

  task automatic test_glitch();
    int c0;
    clear();
    c0 = cyc;
    rx = 0;
    idle(5);
    rx = 1;
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b exp 1", rx_busy); end
    idle(8);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b exp 0 at +%0d", rx_busy, cyc - c0); end
    idle(200);
    checks++; if (got.size() != 0 || vcnt != 0 || fe_cnt != 0 || ov_cnt != 0) begin errors++; $display("FAIL glitch_quiet got n=%0d v=%0d fe=%0d ov=%0d exp 0", got.size(), vcnt, fe_cnt, ov_cnt); end
  endtask

  task automatic test_bad_stop();
    int c0;
    clear();
    c0 = cyc;
    send(8'h3C, 1'b0);
    idle(40);
    checks++; if (fe_cnt != 1 || fe_cyc != c0 + LAT) begin errors++; $display("FAIL bad_stop_ferr got n=%0d at %0d exp 1 at %0d", fe_cnt, fe_cyc - c0, LAT); end
    checks++; if (vcnt != 0 || pe_cnt != 0) begin errors++; $display("FAIL bad_stop_valid got v=%0d pe=%0d exp 0 0", vcnt, pe_cnt); end
  endtask

  task automatic test_overrun();
    clear();
    dout_ready = 0;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    idle(20);
    checks++; if (dout !== 8'h11 || dout_valid !== 1'b1) begin errors++; $display("FAIL overrun_hold got %h v=%b exp 11 v=1", dout, dout_valid); end
    checks++; if (ov_cnt != 1) begin errors++; $display("FAIL overrun_pulse got %0d exp 1", ov_cnt); end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL overrun_early got n=%0d exp 0", got.size()); end
    dout_ready = 1;
    idle(1);
    checks++; if (got.size() != 1 || got[0] !== 8'h11) begin errors++; $display("FAIL overrun_drain got n=%0d %h exp 1 11", got.size(), got.size() ? got[0] : 8'hxx); end
    checks++; if (dout_valid !== 1'b0 || dout !== 8'h11) begin errors++; $display("FAIL overrun_after got v=%b %h exp v=0 11", dout_valid, dout); end
    idle(20);
  endtask

  task automatic test_back_to_back();
    clear();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h55, 1'b1);
    idle(40);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", got.size()); end
    checks++; if (got.size() == 3 && (got[0] !== 8'h00 || got[1] !== 8'hFF || got[2] !== 8'h55)) begin errors++; $display("FAIL b2b_order got %h %h %h exp 00 ff 55", got[0], got[1], got[2]); end
    checks++; if (fe_cnt != 0 || ov_cnt != 0 || pe_cnt != 0) begin errors++; $display("FAIL b2b_flags got fe=%0d ov=%0d pe=%0d exp 0", fe_cnt, ov_cnt, pe_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b = 8'h81;
    clear();
    bitp(1'b0);
    for (int i = 0; i < 4; i++) bitp(b[i]);
    rx = b[4];
    idle(N / 2);
    rst = 1;
    #1;
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got %b exp 0", rx_busy); end
    rx = 1;
    idle(3);
    rst = 0;
    idle(20);
    send(8'h7E, 1'b1);
    idle(40);
    checks++; if (got.size() != 1 || got[0] !== 8'h7E) begin errors++; $display("FAIL reset_mid_byte got n=%0d %h exp 1 7e", got.size(), got.size() ? got[0] : 8'hxx); end
`ifdef LINK_RX_PARITY_EN
    clear();
    send(8'h7E, 1'b1, 1'b1);
    idle(40);
    checks++; if (pe_cnt != 1 || got.size() != 0) begin errors++; $display("FAIL parity_bad got pe=%0d n=%0d exp 1 0", pe_cnt, got.size()); end
`endif
  endtask

  initial begin
    test_reset();
    test_clean();
    test_glitch();
    test_bad_stop();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
